rtc_lect_secuenciador: RTL

- Downstream consumer of the read-window flag generator; turns its periodic flag into a multiplexed-bus read burst on the RTC.
- Drives the generator's enable and uses each flag-high window as one bus phase: an address write, then a data read.
- Reads NREG consecutive RTC registers and captures the bytes into a flat output vector.
- Raises one `valid` pulse when the burst completes; aborts with an error flag on timeout.

---
 rtl/rtc_lect_secuenciador.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/rtc_lect_secuenciador.sv
// rtc_lect_secuenciador: turns read-window flags into an RTC address/data read burst of NREG registers.
// Optional BCD_CHECK_EN flags non-BCD captured bytes in err.  Revision: 1.0
`default_nettype none

module rtc_lect_secuenciador #(
  parameter int         NREG      = 3,
  parameter logic [7:0] ADDR0     = 8'h21,
  parameter logic [7:0] ADDR_STEP = 8'h01,
  parameter int         TIMEOUT   = 63
) (
  input  logic              clkL,
  input  logic              resetL,
  input  logic              startL,
  input  logic              bandL,
  input  logic [7:0]        ad_in,
  output logic              en_band,
  output logic              cs_n,
  output logic              rd_n,
  output logic              wr_n,
  output logic              a_d,
  output logic [7:0]        ad_out,
  output logic              ad_oe,
  output logic [8*NREG-1:0] datos,
  output logic              valid,
  output logic              busy,
  output logic              err
);

  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR_WAIT = 3'd1,
    ADDR      = 3'd2,
    DATA_WAIT = 3'd3,
    DATA      = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t            state, state_n;
  logic [IW-1:0]     idx, idx_n;
  logic [TW-1:0]     cnt, cnt_n;
  logic              band_q;
  logic              en_band_n, cs_n_n, rd_n_n, wr_n_n, a_d_n, ad_oe_n;
  logic              valid_n, busy_n, err_n;
  logic [7:0]        ad_out_n;
  logic [8*NREG-1:0] datos_n;
  logic [7:0]        idx_ext;
  logic              rise, fall, expired, abort;

  assign rise    = bandL & ~band_q;
  assign fall    = ~bandL & band_q;
  assign expired = (cnt == TW'(TIMEOUT));
  assign idx_ext = 8'(idx);

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    en_band_n = en_band;
    cs_n_n    = cs_n;
    rd_n_n    = rd_n;
    wr_n_n    = wr_n;
    a_d_n     = a_d;
    ad_out_n  = ad_out;
    ad_oe_n   = ad_oe;
    datos_n   = datos;
    valid_n   = 1'b0;
    err_n     = err;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (startL) begin
          state_n   = ADDR_WAIT;
          idx_n     = '0;
          en_band_n = 1'b1;
          err_n     = 1'b0;
        end
      end
      ADDR_WAIT: begin
        if (rise) begin
          state_n  = ADDR;
          cs_n_n   = 1'b0;
          wr_n_n   = 1'b0;
          a_d_n    = 1'b0;
          ad_oe_n  = 1'b1;
          ad_out_n = ADDR0 + idx_ext * ADDR_STEP;
        end else begin
          abort = expired;
        end
      end
      ADDR: begin
        if (fall) begin
          state_n = DATA_WAIT;
          cs_n_n  = 1'b1;
          wr_n_n  = 1'b1;
          ad_oe_n = 1'b0;
        end else begin
          abort = expired;
        end
      end
      DATA_WAIT: begin
        if (rise) begin
          state_n = DATA;
          cs_n_n  = 1'b0;
          rd_n_n  = 1'b0;
          a_d_n   = 1'b1;
          ad_oe_n = 1'b0;
        end else begin
          abort = expired;
        end
      end
      DATA: begin
        if (fall) begin
          cs_n_n = 1'b1;
          rd_n_n = 1'b1;
          for (int i = 0; i < NREG; i++) begin
            if (idx == IW'(i)) datos_n[8*i +: 8] = ad_in;
          end
`ifdef BCD_CHECK_EN
          if ((ad_in[7:4] > 4'd9) || (ad_in[3:0] > 4'd9)) err_n = 1'b1;
`endif
          if (idx == IW'(NREG - 1)) begin
            state_n   = DONE;
            valid_n   = 1'b1;
            en_band_n = 1'b0;
          end else begin
            state_n = ADDR_WAIT;
            idx_n   = idx + 1'b1;
          end
        end else begin
          abort = expired;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // A band edge in the same cycle as expiry takes the normal path above.
    if (abort) begin
      state_n   = IDLE;
      err_n     = 1'b1;
      en_band_n = 1'b0;
      cs_n_n    = 1'b1;
      rd_n_n    = 1'b1;
      wr_n_n    = 1'b1;
      ad_oe_n   = 1'b0;
    end
    if (state_n != state) cnt_n = '0;
    else if (!expired)    cnt_n = cnt + 1'b1;
    else                  cnt_n = cnt;
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clkL or negedge resetL) begin
    if (!resetL) begin
      state   <= IDLE;
      idx     <= '0;
      cnt     <= '0;
      band_q  <= 1'b0;
      en_band <= 1'b0;
      cs_n    <= 1'b1;
      rd_n    <= 1'b1;
      wr_n    <= 1'b1;
      a_d     <= 1'b0;
      ad_out  <= 8'h00;
      ad_oe   <= 1'b0;
      datos   <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      cnt     <= cnt_n;
      band_q  <= bandL;
      en_band <= en_band_n;
      cs_n    <= cs_n_n;
      rd_n    <= rd_n_n;
      wr_n    <= wr_n_n;
      a_d     <= a_d_n;
      ad_out  <= ad_out_n;
      ad_oe   <= ad_oe_n;
      datos   <= datos_n;
      valid   <= valid_n;
      busy    <= busy_n;
      err     <= err_n;
    end
  end

endmodule

`default_nettype wire
